// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef logic [1:0] div_state_t;

  localparam div_state_t IDLE = 2'd0;
  localparam div_state_t CALC = 2'd1;
  localparam div_state_t SIGN = 2'd2;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Trial subtract over WIDTH+1 bits; the top bit of trial is the borrow/sign.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider with start/done handshake.
// Optional feature: define DIV_SIGNED_EN for signed two's complement operands.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_t state, state_nxt;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_r, quo_r, div_r, x_r;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] x_abs, y_abs;
  logic [WIDTH-1:0] res_q, res_r;
  logic             dz_r;
  logic             special;

`ifdef DIV_SIGNED_EN
  logic ovf;
  logic ovf_r, neg_q_r, neg_r_r;

  // Operand magnitudes and detection of the one unrepresentable quotient.
  always_comb begin
    x_abs   = x[WIDTH-1] ? -x : x;
    y_abs   = y[WIDTH-1] ? -y : y;
    ovf     = (x == {1'b1, {(WIDTH-1){1'b0}}}) && (y == '1);
    special = (y == '0) || ovf;
  end
`else
  // Unsigned operands are used as-is; only divide-by-zero bypasses CALC.
  always_comb begin
    x_abs   = x;
    y_abs   = y;
    special = (y == '0);
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .quo     (quo_r),
    .divisor (div_r),
    .rem_nxt (rem_step),
    .quo_nxt (quo_step)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special ? SIGN : CALC;
      CALC:    if (count == '0) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Final result selection, including special cases and sign correction.
  always_comb begin
    res_q = quo_r;
    res_r = rem_r;
    if (dz_r) begin
      res_q = '1;
      res_r = x_r;
    end
`ifdef DIV_SIGNED_EN
    else if (ovf_r) begin
      res_q = {1'b1, {(WIDTH-1){1'b0}}};
      res_r = '0;
    end else begin
      res_q = neg_q_r ? -quo_r : quo_r;
      res_r = neg_r_r ? -rem_r : rem_r;
    end
`endif
  end

  // Operand load, iteration registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      div_r       <= '0;
      x_r         <= '0;
      dz_r        <= 1'b0;
`ifdef DIV_SIGNED_EN
      ovf_r       <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            rem_r <= '0;
            quo_r <= x_abs;
            div_r <= y_abs;
            x_r   <= x;
            dz_r  <= (y == '0);
            count <= CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
            ovf_r   <= ovf;
            neg_q_r <= x[WIDTH-1] ^ y[WIDTH-1];
            neg_r_r <= x[WIDTH-1];
`endif
          end
        end
        CALC: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          count <= count - CW'(1);
        end
        SIGN: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          quotient    <= res_q;
          remainder   <= res_r;
          div_by_zero <= dz_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus random operands vs. an arithmetic model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x, y;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: quotient/remainder from plain arithmetic plus the special-case rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int lat);
    dz  = (b == 32'h0);
    lat = 33;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end
`ifdef DIV_SIGNED_EN
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0; lat = 1;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
`else
    else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  // Issue one operation from the current cycle; optionally pulse start again while busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inject);
    logic [31:0] eq, er;
    logic        edz;
    int          lat, n;
    logic        busy_bad;
    model(a, b, eq, er, edz, lat);
    start = 1'b1; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0; x = $urandom; y = $urandom;
    chk("busy_after_e0", busy, 1);
    chk("done_after_e0", done, 0);
    n = 0; busy_bad = 1'b0;
    while (n < 40) begin
      if (n + 1 == inject) begin start = 1'b1; x = $urandom; y = $urandom; end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (done) break;
      if (!busy) busy_bad = 1'b1;
    end
    if (!done) chk("timeout", 0, 1);
    chk("latency", 32'(n), 32'(lat));
    chk("busy_held", busy_bad, 0);
    chk("busy_at_done", busy, 0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edz);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_quo"}, quotient, 0);
    chk({tag, "_rem"}, remainder, 0);
    chk({tag, "_dz"}, div_by_zero, 0);
  endtask

  initial begin
    logic done_seen;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 0);
    run_op(32'd5, 32'd0, 0);
`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FF9C, 32'd7, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(32'h8000_0000, 32'd1, 0);
    run_op(32'd100, 32'hFFFF_FFF9, 0);
`else
    run_op(32'hFFFF_FFFF, 32'd2, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
`endif

    // start pulsed at E10 is ignored and nothing is queued behind it
    run_op(32'd1000, 32'd33, 10);
    repeat (2) @(posedge clk);
    #1 chk("no_queue_busy", busy, 0);

    // reset mid-CALC aborts without a done
    start = 1'b1; x = 32'd12345; y = 32'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    @(negedge clk); rst = 1'b0;
    done_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) done_seen = 1'b1;
    end
    chk("abort_no_done", done_seen, 0);
    run_op(32'd9, 32'd3, 0);

    // random operands, occasionally with zero or small divisors
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if (i % 6 == 5) rb = ra;
      run_op(ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
